// File: rtl/video_stream_tx_pkg.sv
// Shared types and helpers for the video_stream_tx pixel-stream transmitter.
// The state encoding lives here so bench monitors can decode the FSM state.
package video_stream_tx_pkg;

    localparam int unsigned PixelSizeDefault = 24;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StVsync  = 3'd1,
        StHsync  = 3'd2,
        StActive = 3'd3,
        StHblank = 3'd4
    } tx_state_e;

    // Packing is R in the low byte, B in the high byte.
    function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {b, g, r};
    endfunction

endpackage

// File: rtl/video_stream_tx_if.sv
// Control, upstream pixel handshake and downstream beat bundle for video_stream_tx.
// master = pixel source / controller side, slave = the transmitter.
interface video_stream_tx_if
    import video_stream_tx_pkg::*;
#(
    parameter int unsigned PIXEL_SIZE = PixelSizeDefault
);
    logic                  start;
    logic                  continuous;
    logic                  pix_valid;
    logic [PIXEL_SIZE-1:0] pix_data;
    logic                  pix_ready;
    logic                  pattern_en;
    logic                  en;
    logic                  hsync;
    logic                  vsync;
    logic [PIXEL_SIZE-1:0] data;
    logic                  busy;
    logic                  frame_done;
    logic [31:0]           frame_count;

    modport master (
        output start, continuous, pix_valid, pix_data, pattern_en,
        input  pix_ready, en, hsync, vsync, data, busy, frame_done, frame_count
    );

    modport slave (
        input  start, continuous, pix_valid, pix_data, pattern_en,
        output pix_ready, en, hsync, vsync, data, busy, frame_done, frame_count
    );
endinterface

// File: rtl/video_stream_tx_test_pattern_gen.sv
// Combinational test pattern: B = frame, G = row, R = column.
// Only built when VIDEO_TX_PATTERN_EN is defined.
`ifdef VIDEO_TX_PATTERN_EN
module test_pattern_gen
    import video_stream_tx_pkg::*;
(
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [7:0]  frame,
    output logic [23:0] pixel
);
    assign pixel = pack_rgb(x, y, frame);
endmodule
`endif

// File: rtl/video_stream_tx.sv
// Pixel-stream transmitter: wraps upstream pixels in vsync/hsync beats with en-low stalls.
// Optional internal test pattern is enabled by defining VIDEO_TX_PATTERN_EN.
module video_stream_tx
    import video_stream_tx_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 4,
    parameter int unsigned FRAME_HEIGHT = 2,
    parameter int unsigned PIXEL_SIZE   = PixelSizeDefault,
    parameter int unsigned HBLANK       = 2
) (
    input logic              clk,
    input logic              reset_n,
    video_stream_tx_if.slave bus
);
    localparam int unsigned XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int unsigned YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int unsigned HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [XW-1:0] XLast  = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] YLast  = YW'(FRAME_HEIGHT - 1);
    localparam logic [HW-1:0] HbLast = HW'((HBLANK > 0) ? HBLANK - 1 : 0);

    tx_state_e             state_q;
    tx_state_e             row_end_state;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [HW-1:0]         hb_q;
    logic                  en_q, hsync_q, vsync_q, busy_q, frame_done_q;
    logic [PIXEL_SIZE-1:0] data_q;
    logic [31:0]           frame_count_q;
    logic                  pat_active;
    logic [PIXEL_SIZE-1:0] pat_pixel;
    logic                  accept;
    logic [PIXEL_SIZE-1:0] next_pixel;
    logic                  row_last;

`ifdef VIDEO_TX_PATTERN_EN
    logic        pattern_q;
    logic [23:0] pat_rgb;

    test_pattern_gen u_pattern (
        .x     (8'(x_q)),
        .y     (8'(y_q)),
        .frame (frame_count_q[7:0]),
        .pixel (pat_rgb)
    );

    assign pat_active = pattern_q;
    assign pat_pixel  = PIXEL_SIZE'(pat_rgb);
`else
    logic unused_pattern_en;
    assign unused_pattern_en = bus.pattern_en;
    assign pat_active        = 1'b0;
    assign pat_pixel         = '0;
`endif

    assign bus.pix_ready = reset_n & (state_q == StActive) & ~pat_active;
    assign accept        = (state_q == StActive) & (pat_active | bus.pix_valid);
    assign next_pixel    = pat_active ? pat_pixel : bus.pix_data;
    assign row_last      = (y_q == YLast);

    // continuous only matters here, at the end of the last row.
    always_comb begin
        row_end_state = StHsync;
        if (row_last) begin
            row_end_state = bus.continuous ? StVsync : StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            hb_q          <= '0;
            en_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
`ifdef VIDEO_TX_PATTERN_EN
            pattern_q     <= 1'b0;
`endif
        end else begin
            en_q         <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    data_q <= '0;
                    if (bus.start) begin
                        state_q <= StVsync;
                        busy_q  <= 1'b1;
                    end
                end
                StVsync: begin
                    en_q    <= 1'b1;
                    vsync_q <= 1'b1;
                    data_q  <= '0;
                    x_q     <= '0;
                    y_q     <= '0;
                    state_q <= StActive;
`ifdef VIDEO_TX_PATTERN_EN
                    pattern_q <= bus.pattern_en;
`endif
                end
                StHsync: begin
                    en_q    <= 1'b1;
                    hsync_q <= 1'b1;
                    data_q  <= '0;
                    x_q     <= '0;
                    state_q <= StActive;
                end
                StActive: begin
                    // No acceptance: en stays low and data holds (stall beat).
                    if (accept) begin
                        en_q   <= 1'b1;
                        data_q <= next_pixel;
                        if (x_q == XLast) begin
                            if (row_last) begin
                                frame_done_q  <= 1'b1;
                                frame_count_q <= frame_count_q + 32'd1;
                            end
                            if (HBLANK == 0) begin
                                state_q <= row_end_state;
                                busy_q  <= (row_end_state != StIdle);
                                if (!row_last) y_q <= y_q + YW'(1);
                            end else begin
                                hb_q    <= '0;
                                state_q <= StHblank;
                            end
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                StHblank: begin
                    data_q <= '0;
                    if (hb_q == HbLast) begin
                        state_q <= row_end_state;
                        busy_q  <= (row_end_state != StIdle);
                        if (!row_last) y_q <= y_q + YW'(1);
                    end else begin
                        hb_q <= hb_q + HW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.en          = en_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.data        = data_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;

endmodule
